// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter.
// Requester ids and the response tag that follows each beat.
package dram_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int PW_DEF = 3;
    localparam int DW_DEF = 8;

    localparam logic ID_CPU = 1'b0;
    localparam logic ID_AUX = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
        logic we;
    } rsp_tag_t;

endpackage

// File: rtl/dram_arbiter_rr_pick2.sv
// Two-way round-robin picker with owner lock.
// Combinational; grant is one-hot or zero.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       owner,
    input  logic       locked,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (locked) begin
            grant[owner] = valid[owner];
        end else if (valid == 2'b11) begin
            grant[~last] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one synchronous data-RAM port between CPU and aux master.
// Winner is registered onto the RAM; a tag routes the response back.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int PW = PW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic          req0_lock,
    input  logic [PW-1:0] req0_page,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic          req1_lock,
    input  logic [PW-1:0] req1_page,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,

    output logic             ram_en,
    output logic             ram_we,
    output logic [PW+AW-1:0] ram_addr,
    output logic [DW-1:0]    ram_wdata,
    input  logic [DW-1:0]    ram_rdata
);

    logic       last_q;
    logic       owner_q;
    logic       locked_q;
    logic [1:0] grant;

    rr_pick2 u_pick (
        .valid  ({req1_valid, req0_valid}),
        .last   (last_q),
        .owner  (owner_q),
        .locked (locked_q),
        .grant  (grant)
    );

    assign req0_ready = grant[0] & ~rst;
    assign req1_ready = grant[1] & ~rst;

    logic          acc;
    logic          acc_id;
    logic          sel_we;
    logic          sel_lock;
    logic [PW-1:0] sel_page;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign acc       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign acc_id    = req1_valid & req1_ready;
    assign sel_we    = acc_id ? req1_we    : req0_we;
    assign sel_lock  = acc_id ? req1_lock  : req0_lock;
    assign sel_page  = acc_id ? req1_page  : req0_page;
    assign sel_addr  = acc_id ? req1_addr  : req0_addr;
    assign sel_wdata = acc_id ? req1_wdata : req0_wdata;

    rsp_tag_t tag1;
    rsp_tag_t tag2;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= ID_AUX;
            owner_q    <= ID_CPU;
            locked_q   <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            tag1       <= '0;
            tag2       <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            ram_en <= acc;
            ram_we <= acc & sel_we;
            if (acc) begin
                ram_addr  <= {sel_page, sel_addr};
                ram_wdata <= sel_wdata;
                last_q    <= acc_id;
                // only the owner can be accepted while locked, so this releases
                locked_q  <= sel_lock;
                owner_q   <= acc_id;
            end
            tag1 <= '{valid: acc, id: acc_id, we: sel_we};
            tag2 <= tag1;
            rsp0_valid <= tag2.valid & (tag2.id == ID_CPU);
            rsp1_valid <= tag2.valid & (tag2.id == ID_AUX);
            if (tag2.valid & ~tag2.we & (tag2.id == ID_CPU)) begin
                rsp0_rdata <= ram_rdata;
            end
            if (tag2.valid & ~tag2.we & (tag2.id == ID_AUX)) begin
                rsp1_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios then random traffic,
// all checked against a transaction-level model of arbitration and RAM.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int AW = 8;
    localparam int PW = 3;
    localparam int DW = 8;
    localparam int NA = 2 ** (PW + AW);
    localparam int NC = 4096;

    logic clk = 1'b0;
    logic rst;

    logic          v  [2];
    logic          we [2];
    logic          lk [2];
    logic [PW-1:0] pg [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];

    logic          rdy0, rdy1;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic             ram_en, ram_we;
    logic [PW+AW-1:0] ram_addr;
    logic [DW-1:0]    ram_wdata, ram_rdata;

    dram_arbiter #(.AW(AW), .PW(PW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v[0]),
        .req0_ready (rdy0),
        .req0_we    (we[0]),
        .req0_lock  (lk[0]),
        .req0_page  (pg[0]),
        .req0_addr  (ad[0]),
        .req0_wdata (wd[0]),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (v[1]),
        .req1_ready (rdy1),
        .req1_we    (we[1]),
        .req1_lock  (lk[1]),
        .req1_page  (pg[1]),
        .req1_addr  (ad[1]),
        .req1_wdata (wd[1]),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // write-first synchronous RAM with a backdoor preload port
    logic [DW-1:0]    mem [NA];
    logic             pre_we = 1'b0;
    logic [PW+AW-1:0] pre_a  = '0;
    logic [DW-1:0]    pre_d  = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                ram_rdata     <= ram_wdata;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [DW-1:0] refmem [NA];
    bit            known  [NA];
    logic          m_last   = 1'b1;
    logic          m_locked = 1'b0;
    logic          m_owner  = 1'b0;
    logic [PW+AW-1:0] m_addr  = '0;
    logic [DW-1:0]    m_wdata = '0;

    bit            e_en  [NC];
    bit            e_we  [NC];
    int            e_rsp [NC];
    bit            e_rd  [NC];
    bit            e_kn  [NC];
    logic [DW-1:0] e_dat [NC];

    int   cyc = 0;
    logic a [2];
    int   nacc [2];
    logic was_rst = 1'b0;

    task automatic step();
        logic g [2];
        logic id;
        logic [PW+AW-1:0] fa;
        #1;
        g[0] = 1'b0;
        g[1] = 1'b0;
        if (!rst) begin
            if (m_locked) begin
                g[m_owner] = v[m_owner];
            end else if (v[0] && v[1]) begin
                g[!m_last] = 1'b1;
            end else begin
                g[0] = v[0];
                g[1] = v[1];
            end
        end
        chk("rdy0", rdy0, g[0]);
        chk("rdy1", rdy1, g[1]);
        a[0] = v[0] & g[0];
        a[1] = v[1] & g[1];
        if (rst) begin
            for (int k = cyc + 1; k < NC; k++) begin
                e_en[k]  = 1'b0;
                e_rsp[k] = 0;
            end
            m_locked = 1'b0;
            m_last   = 1'b1;
            m_addr   = '0;
            m_wdata  = '0;
        end else if (a[0] || a[1]) begin
            id = a[1];
            fa = {pg[id], ad[id]};
            e_en[cyc+1] = 1'b1;
            e_we[cyc+1] = we[id];
            m_addr  = fa;
            m_wdata = wd[id];
            if (we[id]) begin
                refmem[fa] = wd[id];
                known[fa]  = 1'b1;
            end
            e_rsp[cyc+3] = int'(id) + 1;
            e_rd[cyc+3]  = !we[id];
            e_kn[cyc+3]  = known[fa];
            e_dat[cyc+3] = refmem[fa];
            m_last   = id;
            m_locked = lk[id];
            m_owner  = id;
            nacc[id]++;
        end
        was_rst = rst;
        @(negedge clk);
        cyc++;
        chk("ram_en", ram_en, e_en[cyc]);
        chk("ram_we", ram_we, e_en[cyc] & e_we[cyc]);
        chk("ram_addr", ram_addr, m_addr);
        chk("ram_wdata", ram_wdata, m_wdata);
        chk("rsp0_valid", rsp0_valid, e_rsp[cyc] == 1);
        chk("rsp1_valid", rsp1_valid, e_rsp[cyc] == 2);
        if (e_rsp[cyc] == 1 && e_rd[cyc] && e_kn[cyc])
            chk("rsp0_rdata", rsp0_rdata, e_dat[cyc]);
        if (e_rsp[cyc] == 2 && e_rd[cyc] && e_kn[cyc])
            chk("rsp1_rdata", rsp1_rdata, e_dat[cyc]);
        if (was_rst) begin
            chk("rst_rdata0", rsp0_rdata, 0);
            chk("rst_rdata1", rsp1_rdata, 0);
        end
    endtask

    task automatic set_req(input int id, input logic vv, input logic w,
                           input logic l, input int p, input int ar,
                           input int d);
        v[id]  = vv;
        we[id] = w;
        lk[id] = l;
        pg[id] = PW'(p);
        ad[id] = AW'(ar);
        wd[id] = DW'(d);
    endtask

    task automatic run_acc(input int id, input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!a[id] && n < 20);
        chk(tag, a[id], 1);
    endtask

    task automatic rand_beat(input int id);
        set_req(id, 1'b1, 1'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
    endtask

    int n;
    int first;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_req(i, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            a[i] = 1'b0;
            nacc[i] = 0;
        end
        pre_we = 1'b1;
        pre_a  = {3'd2, 8'h15};
        pre_d  = 8'hA7;
        refmem[{3'd2, 8'h15}] = 8'hA7;
        known[{3'd2, 8'h15}]  = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
        @(negedge clk);

        repeat (3) step();
        rst = 1'b0;

        // tie right after reset
        nacc[0] = 0;
        nacc[1] = 0;
        first = -1;
        set_req(0, 1'b1, 1'b0, 1'b0, 1, $urandom_range(0, 255), 0);
        set_req(1, 1'b1, 1'b0, 1'b0, 1, $urandom_range(0, 255), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            for (int j = 0; j < 2; j++) begin
                if (a[j]) begin
                    if (first < 0) first = j;
                    set_req(j, 1'b1, 1'b0, 1'b0, 1, $urandom_range(0, 255), 0);
                end
            end
        end
        chk("tie_first", first, 0);
        chk("tie_n0", nacc[0], 4);
        chk("tie_n1", nacc[1], 4);
        v[0] = 1'b0;
        v[1] = 1'b0;
        repeat (3) step();

        // single read of preloaded word
        set_req(0, 1'b1, 1'b0, 1'b0, 2, 'h15, 0);
        run_acc(0, "rd_acc", n);
        v[0] = 1'b0;
        chk("rd_ram_en", ram_en, 1);
        chk("rd_ram_addr", ram_addr, 'h215);
        step();
        step();
        chk("rd_rsp0_v", rsp0_valid, 1);
        chk("rd_rsp0_d", rsp0_rdata, 'hA7);
        chk("rd_rsp1_v", rsp1_valid, 0);

        // aux holds a 3-beat locked write burst
        set_req(1, 1'b1, 1'b1, 1'b1, 3, 'h10, 'h11);
        run_acc(1, "lk_b1", n);
        set_req(0, 1'b1, 1'b0, 1'b0, 3, 'h10, 0);
        set_req(1, 1'b1, 1'b1, 1'b1, 3, 'h11, 'h22);
        run_acc(1, "lk_b2", n);
        set_req(1, 1'b1, 1'b1, 1'b0, 3, 'h12, 'h33);
        run_acc(1, "lk_b3", n);
        chk("lk_blk", nacc[0] > 0 && a[0], 0);
        v[1] = 1'b0;
        run_acc(0, "lk_rel_acc", n);
        chk("lk_rel_n", n, 1);
        v[0] = 1'b0;
        repeat (3) step();

        // owner goes idle while holding the lock
        set_req(0, 1'b1, 1'b1, 1'b1, 4, 'h01, 'h5A);
        run_acc(0, "idle_lock", n);
        v[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 1'b0, 4, 'h01, 0);
        repeat (3) begin
            step();
            chk("idle_noacc", a[1], 0);
        end
        set_req(0, 1'b1, 1'b0, 1'b0, 4, 'h02, 0);
        run_acc(0, "idle_rel", n);
        v[0] = 1'b0;
        run_acc(1, "idle_aux", n);
        v[1] = 1'b0;
        repeat (3) step();

        // read-after-write on consecutive beats
        set_req(0, 1'b1, 1'b1, 1'b0, 0, 'h40, 'h3C);
        run_acc(0, "raw_wr", n);
        v[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 1'b0, 0, 'h40, 0);
        run_acc(1, "raw_rd", n);
        chk("raw_n", n, 1);
        v[1] = 1'b0;
        step();
        step();
        chk("raw_v", rsp1_valid, 1);
        chk("raw_d", rsp1_rdata, 'h3C);
        repeat (3) step();

        // reset with two reads in flight
        set_req(0, 1'b1, 1'b0, 1'b0, 2, 'h15, 0);
        run_acc(0, "rr_a", n);
        run_acc(0, "rr_b", n);
        v[0] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_addr", ram_addr, 0);
        chk("rr_en", ram_en, 0);
        repeat (4) begin
            step();
            chk("rr_norsp", rsp0_valid | rsp1_valid, 0);
        end

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (a[j] || !v[j]) begin
                    if ($urandom_range(0, 9) < 6) rand_beat(j);
                    else v[j] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        v[0] = 1'b0;
        v[1] = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
